ffbank_arbiter: RTL and testbench
=================================

# ffbank_arbiter

Sequencer and round-robin arbiter for a shared bank of WIDTH `FLIPFLOP` cells. Each cell has D, clock, preset and clear inputs.
- Up to NREQ requesters issue load, preset, clear or read operations.
- The block grants one requester at a time and generates the bank's `data`, `clk`, `preset` and `clear` stimulus with fixed setup and hold.
- It returns the sampled bank output.
- It sits between requester logic and the flip-flop bank; nothing else drives the bank.

## Interface
- WIDTH, 8, bank width in bits.
- NREQ, 4, number of requesters (2..8).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until that requester's `done`.
- op  input  2*NREQ  per-requester opcode, slice i = op[2i+1:2i]: 00 LOAD, 01 PRESET, 10 CLEAR, 11 READ.
- wdata  input  WIDTH*NREQ  per-requester load data, slice i = wdata[WIDTH*i +: WIDTH].
- gnt  output  NREQ  one-hot grant, high from SETUP through DONE.
- done  output  1  one-cycle completion pulse.
- rdata  output  WIDTH  bank value sampled at end of operation; valid while `done` is high, held until the next `done`.
- busy  output  1  high in any state except IDLE.
- ff_d  output  WIDTH  bank D inputs.
- ff_clk  output  1  generated bank clock.
- ff_preset  output  1  bank preset, active-high.
- ff_clear  output  1  bank clear, active-high.
- ff_q  input  WIDTH  bank Q outputs.

## Operation
- The FSM has four states: IDLE → SETUP → PULSE → DONE → IDLE.
- **IDLE:** if any `req` bit is high, pick a winner round-robin and register its index, op and data. Set `gnt` and go to SETUP. Otherwise stay in IDLE.
- **Round-robin:** search starts at (last winner + 1) mod NREQ. After reset the pointer is 0, so requester 0 has top priority.
- **SETUP:**
  - LOAD drives `ff_d` = latched data with `ff_clk` = 0.
  - PRESET asserts `ff_preset`; CLEAR asserts `ff_clear`.
  - READ drives nothing.
  - `ff_d` holds the latched data for every op.
- **PULSE:**
  - LOAD drives `ff_clk` = 1.
  - PRESET and CLEAR keep their strobe asserted.
  - READ idles.
  - At the end of PULSE, `ff_q` is registered into `rdata`.
- **DONE:**
  - `ff_clk`, `ff_preset` and `ff_clear` return to 0.
  - `ff_d` is held.
  - `done` = 1 and `gnt` stays asserted for this cycle.
  - The next state is always IDLE.
- `ff_preset` and `ff_clear` are never high together. `ff_clk` is high only during PULSE of a LOAD.
- Every op has the same length, so scheduling does not depend on op type.
- **Request edge cases:**
  - Dropping `req` mid-transaction does not abort it.
  - `op` and `wdata` changes after the IDLE capture are ignored.
  - A request that arrives during busy waits for the next IDLE.
- **Output encoding:** every output is registered, straight from flops, with no combinational paths from `req` to outputs.

## Timing
- **Reset values:** `gnt`=0, `done`=0, `busy`=0, `rdata`=0, `ff_d`=0, `ff_clk`=0, `ff_preset`=0, `ff_clear`=0, state IDLE, pointer 0.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronously). A pending `ff_clk` high drops to 0, and the interrupted transaction never pulses `done`.
- **Latency:**
  - `req` sampled at edge N gives `gnt` and `busy` high from N+1.
  - Bank strobe in cycle N+2.
  - `done` in cycle N+3.
  - `busy` low from N+4.
- **Throughput:** one transaction per 4 cycles. A requester still holding `req` after its `done` is re-arbitrated in IDLE like any other requester.
- **Setup and hold for LOAD:** `ff_d` is stable one full cycle before `ff_clk` rises and one full cycle after it falls.

## Structure
- Shared package `ffbank_pkg` holds:
  - op encodings OP_LOAD/OP_PRESET/OP_CLEAR/OP_READ;
  - state encodings S_IDLE/S_SETUP/S_PULSE/S_DONE;
  - NREQ/WIDTH defaults.
- One sub-module `rr_arbiter`, parameterised by NREQ: `req` plus pointer in, one-hot grant and index out, purely combinational.
- The FSM, latches and pointer live in `ffbank_arbiter`.

## Test plan
- **Reset:** rst high with random inputs → all outputs 0. Release, no `req` → `busy` stays 0 for 10 cycles.
- **LOAD then READ:** req[0] LOAD wdata=8'hA5 → `gnt`=4'b0001 at N+1, `ff_clk` high only at N+2, `done` at N+3, `rdata`=8'hA5. Follow with req[0] READ → `rdata`=8'hA5, no `ff_clk` pulse.
- **PRESET/CLEAR:** req[2] PRESET → `ff_preset` high in cycles N+1..N+2 only, `rdata`=8'hFF. Then req[2] CLEAR → `rdata`=8'h00, with `ff_preset` and `ff_clear` never both high.
- **Round-robin fairness:** all four `req` held high continuously → grants in order 0,1,2,3,0, one `done` every 4 cycles.
- **Mid-operation changes:** req[1] LOAD 8'h3C, then drop `req` and change `wdata` to 8'hFF during SETUP → transaction completes with `rdata`=8'h3C.
- **Reset during PULSE:** assert rst in PULSE of a LOAD → `ff_clk` drops immediately, no `done`. After release, req[3] → granted first (pointer reset to 0, no lower requester pending).

Source files
------------

// File: rtl/ffbank_pkg.sv
// Shared encodings and defaults for the flip-flop bank sequencer/arbiter.
package ffbank_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_PRESET = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_PULSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Round-robin successor of a winner index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
  import ffbank_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [IW-1:0] pos_s;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[pos_s]) begin
        gnt[pos_s] = 1'b1;
        idx        = pos_s;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ffbank_arbiter.sv
// Grants one requester at a time and sequences the shared flip-flop bank
// through SETUP/PULSE/DONE; all outputs come straight from flops.
module ffbank_arbiter
  import ffbank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic [WIDTH-1:0]      ff_d,
  output logic                  ff_clk,
  output logic                  ff_preset,
  output logic                  ff_clear,
  input  logic [WIDTH-1:0]      ff_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] ff_d_q, ff_d_d;
  logic             ff_clk_q, ff_clk_d;
  logic             ff_preset_q, ff_preset_d;
  logic             ff_clear_q, ff_clear_d;

  logic [NREQ-1:0]  arb_gnt_s;
  logic [IW-1:0]    arb_idx_s;
  logic             arb_found_s;
  op_e              sel_op_s;
  logic [WIDTH-1:0] sel_wdata_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .found (arb_found_s)
  );

  always_comb begin
    sel_op_s    = op_e'(op[2*int'(arb_idx_s) +: 2]);
    sel_wdata_s = wdata[WIDTH*int'(arb_idx_s) +: WIDTH];
  end

  // Strobes are set one state early so the registered outputs line up with
  // the state they belong to; ff_d is only ever written at capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    rdata_d     = rdata_q;
    ff_d_d      = ff_d_q;
    ff_clk_d    = 1'b0;
    ff_preset_d = ff_preset_q;
    ff_clear_d  = ff_clear_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found_s) begin
          state_d     = S_SETUP;
          idx_d       = arb_idx_s;
          op_d        = sel_op_s;
          gnt_d       = arb_gnt_s;
          busy_d      = 1'b1;
          ff_d_d      = sel_wdata_s;
          ff_preset_d = (sel_op_s == OP_PRESET);
          ff_clear_d  = (sel_op_s == OP_CLEAR);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d  = S_PULSE;
        ff_clk_d = (op_q == OP_LOAD);
      end
      S_PULSE: begin
        state_d     = S_DONE;
        ff_preset_d = 1'b0;
        ff_clear_d  = 1'b0;
        rdata_d     = ff_q;
        done_d      = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = IW'(rr_next(int'(idx_q), NREQ));
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        busy_d      = 1'b0;
        ff_preset_d = 1'b0;
        ff_clear_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      ff_d_q      <= '0;
      ff_clk_q    <= 1'b0;
      ff_preset_q <= 1'b0;
      ff_clear_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      ff_d_q      <= ff_d_d;
      ff_clk_q    <= ff_clk_d;
      ff_preset_q <= ff_preset_d;
      ff_clear_q  <= ff_clear_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign ff_d      = ff_d_q;
  assign ff_clk    = ff_clk_q;
  assign ff_preset = ff_preset_q;
  assign ff_clear  = ff_clear_q;

endmodule

// File: tb/tb_ffbank_arbiter.sv
// Self-checking bench: behavioural flip-flop bank plus a transaction-schedule
// reference model checked every cycle, with directed and random stimulus.
module tb_ffbank_arbiter;
  import ffbank_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  done, busy, ff_clk, ff_preset, ff_clear;
  logic [WIDTH-1:0]      rdata, ff_d, ff_q;
  logic [WIDTH-1:0]      bank_r = 8'h00;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: one transaction schedule relative to its capture edge
  bit         m_active = 1'b0;
  int         m_edge   = 0;
  int         m_start  = 0;
  int         m_win    = 0;
  int         m_ptr    = 0;
  logic [1:0] m_op     = 2'b00;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] m_bank   = 8'h00;
  logic [7:0] m_rdata  = 8'h00;
  logic [7:0] m_ffd    = 8'h00;
  int         win_log[$];
  int         done_cnt = 0;

  always #5 clk = ~clk;

  ffbank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .ff_d      (ff_d),
    .ff_clk    (ff_clk),
    .ff_preset (ff_preset),
    .ff_clear  (ff_clear),
    .ff_q      (ff_q)
  );

  assign ff_q = bank_r;

  always @(posedge ff_clk or posedge ff_preset or posedge ff_clear) begin
    if (ff_preset)     bank_r <= 8'hFF;
    else if (ff_clear) bank_r <= 8'h00;
    else               bank_r <= ff_d;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_ptr    = 0;
    m_rdata  = 8'h00;
    m_ffd    = 8'h00;
  endtask

  task automatic model_edge();
    int d;
    bit hit;
    m_edge++;
    if (rst) begin
      model_reset();
    end else if (m_active) begin
      d = m_edge - m_start;
      if (d == 1 && m_op == OP_LOAD) m_bank = m_data;
      if (d == 2) m_rdata = m_bank;
      if (d == 3) begin
        m_active = 1'b0;
        m_ptr    = (m_win + 1) % NREQ;
      end
    end else if (req != '0) begin
      hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!hit && req[(m_ptr + k) % NREQ]) begin
          m_win = (m_ptr + k) % NREQ;
          hit   = 1'b1;
        end
      end
      m_op     = op[2*m_win +: 2];
      m_data   = wdata[8*m_win +: 8];
      m_ffd    = m_data;
      m_start  = m_edge;
      m_active = 1'b1;
      win_log.push_back(m_win);
      if (m_op == OP_PRESET)     m_bank = 8'hFF;
      else if (m_op == OP_CLEAR) m_bank = 8'h00;
    end
  endtask

  task automatic check_outputs();
    int d;
    d = m_edge - m_start;
    check_eq("gnt",    32'(gnt),    m_active ? (32'd1 << m_win) : 32'd0);
    check_eq("busy",   32'(busy),   32'(m_active));
    check_eq("done",   32'(done),   32'(m_active && d == 2));
    check_eq("ff_clk", 32'(ff_clk), 32'(m_active && d == 1 && m_op == OP_LOAD));
    check_eq("ff_preset", 32'(ff_preset), 32'(m_active && d <= 1 && m_op == OP_PRESET));
    check_eq("ff_clear",  32'(ff_clear),  32'(m_active && d <= 1 && m_op == OP_CLEAR));
    check_eq("ff_d",   32'(ff_d),   32'(m_ffd));
    check_eq("rdata",  32'(rdata),  32'(m_rdata));
    check_eq("pc_excl", 32'(ff_preset & ff_clear), 32'd0);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] dat);
    op[2*i +: 2]    = o;
    wdata[8*i +: 8] = dat;
    req[i]          = 1'b1;
  endtask

  // Requester i holds req through done, then drops it.
  task automatic run_txn(input string tag, input int i, input logic [1:0] o,
                         input logic [7:0] dat, input logic [7:0] exp_rd);
    set_req(i, o, dat);
    tick();
    tick();
    tick();
    check_eq({tag, "_done"},  32'(done),  32'd1);
    check_eq({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    req[i] = 1'b0;
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'($urandom);
    op    = 8'($urandom);
    wdata = 32'($urandom);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      req   = 4'($urandom);
      op    = 8'($urandom);
      wdata = 32'($urandom);
    end
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 10; i++) tick();

    // All requesters held: strict rotation from requester 0.
    win_log.delete();
    done_cnt = 0;
    req   = 4'b1111;
    op    = 8'($urandom);
    wdata = 32'($urandom);
    for (int i = 0; i < 20; i++) tick();
    req = 4'b0000;
    check_eq("rr_count", 32'(win_log.size()), 32'd5);
    check_eq("rr_done_cnt", 32'(done_cnt), 32'd5);
    for (int k = 0; k < 5; k++)
      check_eq("rr_order", (k < win_log.size()) ? 32'(win_log[k]) : 32'hFFFF_FFFF, 32'(k % NREQ));
    tick();

    run_txn("load_a5", 0, OP_LOAD,   8'hA5, 8'hA5);
    run_txn("read_a5", 0, OP_READ,   8'h00, 8'hA5);
    run_txn("preset",  2, OP_PRESET, 8'h11, 8'hFF);
    run_txn("clear",   2, OP_CLEAR,  8'h22, 8'h00);

    // req dropped and wdata changed during SETUP must not affect the transaction.
    set_req(1, OP_LOAD, 8'h3C);
    tick();
    req[1]      = 1'b0;
    wdata[15:8] = 8'hFF;
    tick();
    tick();
    check_eq("midop_rdata", 32'(rdata), 32'h3C);
    tick();

    // Reset asserted during PULSE of a LOAD.
    set_req(0, OP_LOAD, 8'h5A);
    tick();
    tick();
    check_eq("pre_rst_clk", 32'(ff_clk), 32'd1);
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #1;
    check_eq("rst_clk",  32'(ff_clk), 32'd0);
    check_eq("rst_gnt",  32'(gnt),    32'd0);
    check_eq("rst_busy", 32'(busy),   32'd0);
    check_eq("rst_done", 32'(done),   32'd0);
    @(negedge clk);
    check_outputs();
    tick();
    rst = 1'b0;
    set_req(3, OP_READ, 8'h00);
    tick();
    check_eq("post_rst_gnt", 32'(gnt), 32'b1000);
    tick();
    tick();
    check_eq("post_rst_rdata", 32'(rdata), 32'h5A);
    req = 4'b0000;
    tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      req   = 4'($urandom & $urandom);
      op    = 8'($urandom);
      wdata = 32'($urandom);
      tick();
    end
    req = 4'b0000;
    for (int i = 0; i < 5; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
